// File: rtl/tlp_fifo_ctrl_pkg.sv
// ============================================================================
// Module      : tlp_fifo_ctrl_pkg
// Description : Shared sizing defaults for the TLP byte FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlp_fifo_ctrl_pkg;

    localparam int c_data_w     = 8;
    localparam int c_addr_w     = 6;
    localparam int c_depth      = 1 << c_addr_w;
    localparam int c_afull_lvl  = 60;
    localparam int c_aempty_lvl = 4;

endpackage : tlp_fifo_ctrl_pkg

`default_nettype wire

// File: rtl/tlp_fifo_ctrl_if.sv
// ============================================================================
// Module      : tlp_fifo_ctrl_if
// Description : Producer/consumer handshake bundle for tlp_fifo_ctrl.
//               Error flags present only when TLP_FIFO_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlp_fifo_ctrl_if
    import tlp_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w
);

    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
`ifdef TLP_FIFO_ERR_EN
    logic              overflow;
    logic              underflow;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
`else
    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count
    );
`endif

endinterface : tlp_fifo_ctrl_if

`default_nettype wire

// File: rtl/true_dpram_sclk.sv
// ============================================================================
// Module      : true_dpram_sclk
// Description : Single-clock true dual-port RAM, read-before-write per port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module true_dpram_sclk #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  wire logic              clk,
    input  wire logic              we_a,
    input  wire logic [ADDR_W-1:0] addr_a,
    input  wire logic [DATA_W-1:0] data_a,
    output      logic [DATA_W-1:0] q_a,
    input  wire logic              we_b,
    input  wire logic [ADDR_W-1:0] addr_b,
    input  wire logic [DATA_W-1:0] data_b,
    output      logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Reads return the pre-write contents, so a same-address write/read
    // on the same edge yields the old word.
    always_ff @(posedge clk) begin
        q_a <= r_mem[addr_a];
        q_b <= r_mem[addr_b];
        if (we_b) begin
            r_mem[addr_b] <= data_b;
        end
        if (we_a) begin
            r_mem[addr_a] <= data_a;
        end
    end

endmodule : true_dpram_sclk

`default_nettype wire

// File: rtl/tlp_fifo_ctrl.sv
// ============================================================================
// Module      : tlp_fifo_ctrl
// Description : Pointer/occupancy controller around true_dpram_sclk for TLP
//               byte buffering. Optional sticky error flags: TLP_FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlp_fifo_ctrl
    import tlp_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int ADDR_W     = c_addr_w,
    parameter int AFULL_LVL  = c_afull_lvl,
    parameter int AEMPTY_LVL = c_aempty_lvl
) (
    input  wire logic       clk,
    input  wire logic       reset,
    tlp_fifo_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] c_full_cnt   = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] c_afull_cnt  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] c_aempty_cnt = (ADDR_W+1)'(AEMPTY_LVL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_valid;

    logic              w_full;
    logic              w_empty;
    logic              w_pop_acc;
    logic              w_push_acc;
    logic              w_we_a;
    logic [DATA_W-1:0] w_q_b;
    logic [DATA_W-1:0] w_q_a_unused;

    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign w_pop_acc  = bus.pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push_acc = bus.push & (~w_full | w_pop_acc);
    assign w_we_a     = w_push_acc & ~reset;

    true_dpram_sclk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we_a   (w_we_a),
        .addr_a (r_wr_ptr),
        .data_a (bus.data_in),
        .q_a    (w_q_a_unused),
        .we_b   (1'b0),
        .addr_b (r_rd_ptr),
        .data_b ({DATA_W{1'b0}}),
        .q_b    (w_q_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_valid <= w_pop_acc;
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef TLP_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push & ~w_push_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_afull_cnt);
    assign bus.almost_empty = (r_count <= c_aempty_cnt);
    assign bus.valid_out    = r_valid;
    assign bus.data_out     = r_valid ? w_q_b : '0;

endmodule : tlp_fifo_ctrl

`default_nettype wire
